// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : Pipelined instruction-fetch front end with PC-tagged FIFO and redirect flush.
// Revision : 1.0
// ============================================================================
module fetch_queue_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_enable,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         icache_req_valid,
    input  logic                         icache_req_ready,
    output logic [ADDR_W-1:0]            icache_req_addr,
    input  logic                         icache_resp_valid,
    input  logic [INST_W-1:0]            icache_resp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INST_W-1:0]            out_inst,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int c_INC    = INST_W / 8;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_OUT_W  = $clog2(MAX_OUT + 1);
    localparam int c_TAG_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [ADDR_W-1:0] c_INC_A      = ADDR_W'(c_INC);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(c_INC - 1);

    logic [ADDR_W-1:0]   r_pc;
    logic [c_OUT_W-1:0]  r_inflight;
    logic [c_OUT_W-1:0]  r_stale;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_TAG_PW-1:0] r_tag_wr;
    logic [c_TAG_PW-1:0] r_tag_rd;
    logic [INST_W-1:0]   r_inst_mem [DEPTH];
    logic [ADDR_W-1:0]   r_pc_mem   [DEPTH];
    logic [ADDR_W-1:0]   r_tag_mem  [MAX_OUT];

    logic [c_OUT_W:0] w_out_sum;
    logic [c_CNT_W:0] w_occ_sum;
    logic             w_fire;
    logic             w_resp_live;
    logic             w_resp_drop;
    logic             w_pop;

    function automatic logic [c_TAG_PW-1:0] f_tag_next(input logic [c_TAG_PW-1:0] p);
        return (p == c_TAG_PW'(MAX_OUT - 1)) ? '0 : p + c_TAG_PW'(1);
    endfunction

    // Stale requests still hold cache credit but no longer reserve FIFO space.
    assign w_out_sum = {1'b0, r_inflight} + {1'b0, r_stale};
    assign w_occ_sum = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight);

    assign icache_req_valid = fetch_enable & ~redirect_valid
                            & (w_out_sum < (c_OUT_W + 1)'(MAX_OUT))
                            & (w_occ_sum < (c_CNT_W + 1)'(DEPTH));
    assign icache_req_addr  = r_pc;

    assign w_fire      = icache_req_valid & icache_req_ready;
    assign w_resp_live = icache_resp_valid & ~redirect_valid & (r_stale == '0);
    assign w_resp_drop = icache_resp_valid & ~redirect_valid & (r_stale != '0);
    assign w_pop       = out_valid & out_ready & ~redirect_valid;

    assign out_valid   = (r_count != '0);
    assign out_inst    = out_valid ? r_inst_mem[r_rd_ptr] : '0;
    assign out_pc      = out_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign queue_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_stale    <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
        end else if (redirect_valid) begin
            // A response landing this cycle retires one of the requests being orphaned.
            r_pc       <= redirect_pc & c_ALIGN_MASK;
            r_stale    <= r_stale + r_inflight - c_OUT_W'(icache_resp_valid);
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
        end else begin
            if (w_fire) begin
                r_pc     <= r_pc + c_INC_A;
                r_tag_wr <= f_tag_next(r_tag_wr);
            end
            if (w_resp_live) begin
                r_tag_rd <= f_tag_next(r_tag_rd);
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_resp_drop) begin
                r_stale <= r_stale - c_OUT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_inflight <= r_inflight + c_OUT_W'(w_fire) - c_OUT_W'(w_resp_live);
            r_count    <= r_count + c_CNT_W'(w_resp_live) - c_CNT_W'(w_pop);
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag_mem[r_tag_wr] <= r_pc;
        end
        if (w_resp_live) begin
            r_inst_mem[r_wr_ptr] <= icache_resp_data;
            r_pc_mem[r_wr_ptr]   <= r_tag_mem[r_tag_rd];
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        w_resp_live |-> (r_count < c_CNT_W'(DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Brief    : Randomised scoreboard bench for fetch_queue_unit with cache model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          ADDR_W  = 64;
    localparam int          INST_W  = 32;
    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [63:0] RST_PC  = 64'hFFFF_FFFF_FFFF_FFF8;

    logic              clk;
    logic              reset;
    logic              fetch_enable;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              icache_req_valid;
    logic              icache_req_ready;
    logic [ADDR_W-1:0] icache_req_addr;
    logic              icache_resp_valid;
    logic [INST_W-1:0] icache_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [2:0]        queue_count;

    fetch_queue_unit #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .RESET_PC(RST_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_enable     (fetch_enable),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_inst         (out_inst),
        .out_pc           (out_pc),
        .queue_count      (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every request ever accepted, oldest first, with a flag
    // saying whether its answer is still wanted; plus the expected FIFO contents.
    typedef struct packed { logic [63:0] addr; logic live; } req_t;
    typedef struct packed { logic [63:0] pc; logic [31:0] inst; } ent_t;
    typedef struct packed { logic [63:0] addr; logic [31:0] due; } pend_t;

    req_t  outst[$];
    ent_t  exp_q[$];
    pend_t pend[$];
    logic [63:0] m_pc;
    int    n_chk;
    int    n_fail;
    int    cyc;
    bit    mon_en;

    int    p_ready, p_resp, p_oready, p_fe, p_redir, lat_min, lat_max;
    bit    rst_req, force_redir, redir_on_resp;
    logic [63:0] force_pc;

    function automatic logic [31:0] idata(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (outst[i]) if (outst[i].live) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic        exp_rv;
        logic        act_rv;
        logic        do_resp;
        logic [63:0] act_addr;
        req_t        r;
        @(negedge clk);
        reset             = rst_req;
        do_resp           = !rst_req && pend.size() > 0 && pend[0].due <= 32'(cyc + 1) && pct(p_resp);
        icache_resp_valid = do_resp;
        icache_resp_data  = do_resp ? idata(pend[0].addr) : $urandom;
        icache_req_ready  = pct(p_ready);
        out_ready         = pct(p_oready);
        fetch_enable      = pct(p_fe);
        redirect_valid    = force_redir || pct(p_redir) || (redir_on_resp && do_resp);
        if (force_redir) redirect_pc = force_pc;
        else case ($urandom_range(2, 0))
            0:       redirect_pc = {$urandom, $urandom};
            1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            default: redirect_pc = 64'($urandom_range(255, 0));
        endcase
        #1;
        act_rv   = icache_req_valid;
        act_addr = icache_req_addr;
        exp_rv   = fetch_enable && !redirect_valid && outst.size() < MAX_OUT
                   && (exp_q.size() + live_cnt()) < DEPTH;
        if (!rst_req) begin
            chk("req_valid", 64'(act_rv), 64'(exp_rv));
            if (exp_rv) chk("req_addr", act_addr, m_pc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_req) begin
            outst.delete();
            exp_q.delete();
            pend.delete();
            m_pc = RST_PC;
        end else begin
            if (icache_resp_valid && outst.size() > 0) begin
                r = outst.pop_front();
                if (!redirect_valid && r.live) exp_q.push_back({r.addr, idata(r.addr)});
            end
            if (icache_resp_valid && pend.size() > 0) void'(pend.pop_front());
            if (redirect_valid) begin
                foreach (outst[i]) outst[i].live = 1'b0;
                exp_q.delete();
                m_pc = redirect_pc & ~64'h3;
            end else if (exp_rv && icache_req_ready) begin
                outst.push_back({m_pc, 1'b1});
                m_pc = m_pc + 64'd4;
            end
            if (act_rv && icache_req_ready)
                pend.push_back({act_addr, 32'(cyc + int'($urandom_range(lat_max, lat_min)))});
        end
    endtask

    task automatic knobs(input int rd, input int rs, input int orr, input int fe,
                         input int rdr, input int lmin, input int lmax);
        p_ready = rd; p_resp = rs; p_oready = orr; p_fe = fe; p_redir = rdr;
        lat_min = lmin; lat_max = lmax;
    endtask

    // Output monitor: compares whatever the DUT presents against the scoreboard.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("queue_count", 64'(queue_count), 64'(exp_q.size()));
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL out_unexpected: got pc %h inst %h, expected no output", out_pc, out_inst);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_inst", 64'(out_inst), 64'(e.inst));
                    end
                end
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; mon_en = 0; m_pc = RST_PC;
        reset = 1'b1; fetch_enable = 0; redirect_valid = 0; redirect_pc = '0;
        icache_req_ready = 0; icache_resp_valid = 0; icache_resp_data = '0; out_ready = 0;
        rst_req = 1; force_redir = 0; redir_on_resp = 0; force_pc = '0;
        knobs(0, 0, 0, 0, 0, 1, 1);
        repeat (2) step();
        rst_req = 0;
        mon_en  = 1;
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_inst", 64'(out_inst), 64'h0);
        chk("rst_queue_count", 64'(queue_count), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);

        // Wrap-around from the reset PC at full throughput.
        knobs(100, 100, 100, 100, 0, 1, 1);
        repeat (12) step();

        // Fill with decode stalled, then drain.
        force_redir = 1; force_pc = 64'h1000;
        step();
        force_redir = 0;
        knobs(100, 100, 0, 100, 0, 1, 1);
        repeat (12) step();
        chk("fill_count", 64'(queue_count), 64'd4);
        chk("fill_head_pc", out_pc, 64'h1000);
        knobs(100, 100, 100, 100, 0, 1, 1);
        repeat (12) step();

        // Misaligned redirect with requests in flight behind long latency.
        knobs(100, 100, 100, 100, 0, 3, 3);
        force_redir = 1; force_pc = 64'h2000;
        step();
        force_redir = 0;
        repeat (2) step();
        force_redir = 1; force_pc = 64'h3002;
        step();
        force_redir = 0;
        repeat (15) step();

        // Redirects landing on response cycles.
        knobs(100, 100, 50, 100, 0, 1, 2);
        redir_on_resp = 1;
        repeat (20) step();
        redir_on_resp = 0;

        // Fetch disabled with work outstanding.
        knobs(100, 100, 100, 100, 0, 2, 2);
        repeat (6) step();
        p_fe = 0;
        repeat (10) step();
        p_fe = 100;
        repeat (10) step();

        // Reset mid-stream together with a redirect.
        rst_req = 1; force_redir = 1; force_pc = 64'h4444;
        step();
        rst_req = 0; force_redir = 0;
        chk("rst2_queue_count", 64'(queue_count), 64'h0);
        chk("rst2_out_valid", 64'(out_valid), 64'h0);
        chk("rst2_out_pc", out_pc, 64'h0);
        chk("rst2_out_inst", 64'(out_inst), 64'h0);
        repeat (10) step();

        // Random soak with knobs reshuffled periodically.
        for (int blk = 0; blk < 20; blk++) begin
            knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 40)),
                  int'($urandom_range(100, 0)), int'($urandom_range(100, 50)),
                  int'($urandom_range(8, 0)), 1, int'($urandom_range(4, 1)));
            redir_on_resp = ($urandom_range(3, 0) == 0);
            rst_req = ($urandom_range(9, 0) == 0);
            step();
            rst_req = 0;
            repeat (150) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
